l2_write_buffer: RTL

Posted write buffer between the victim cache's memory-side port and physical memory. Dirty L2/victim line writebacks are acknowledged upstream after one cycle and drained to physical memory in the background. Line fills (reads) take priority over draining and are serviced from the buffer when the line is still pending. Upstream ports use the L2-line-side handshake; downstream ports drive physical memory directly.

---
 rtl/l2_write_buffer_if.sv | 16 +
 rtl/l2_write_buffer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/l2_write_buffer_if.sv
// rtl/l2_write_buffer_if.sv - line-granular request/response bus used on both sides of the write buffer
// The requester drives read/write/address/wdata and the responder returns resp/rdata.
interface l2_write_buffer_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 256
) ();
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [LINE_W-1:0] wdata;
  logic              resp;
  logic [LINE_W-1:0] rdata;

  modport master (output read, write, address, wdata, input resp, rdata);
  modport slave  (input read, write, address, wdata, output resp, rdata);
endinterface

// File: rtl/l2_write_buffer.sv
// rtl/l2_write_buffer.sv - posted line write buffer between the victim cache and physical memory
// Optional L2_WB_COALESCE_EN: writes to a line already buffered overwrite it in place.
module l2_write_buffer #(
  parameter int DEPTH    = 4,
  parameter int LINE_W   = 256,
  parameter int ADDR_W   = 16,
  parameter int OFFSET_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  l2_write_buffer_if.slave   up,
  l2_write_buffer_if.master  pmem,
  output logic               wb_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {IDLE, RESP, PMEM_RD, PMEM_WR} state_t;

  state_t              r_state;
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;
  logic [DEPTH-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag  [DEPTH];
  logic [LINE_W-1:0]   r_data [DEPTH];
  logic                r_mem_resp;
  logic [LINE_W-1:0]   r_mem_rdata;
  logic                r_pmem_read;
  logic                r_pmem_write;
  logic [ADDR_W-1:0]   r_pmem_address;
  logic [LINE_W-1:0]   r_pmem_wdata;

  logic [TAG_W-1:0]    w_req_tag;
  logic                w_hit;
  logic [PTR_W-1:0]    w_hit_idx;
  logic                w_full;
  logic                w_unused_offset;

  assign w_req_tag       = up.address[ADDR_W-1:OFFSET_W];
  assign w_unused_offset = ^up.address[OFFSET_W-1:0];
  assign w_full          = (r_count == CNT_W'(DEPTH));

  // Walk oldest to youngest so the last match wins: reads must see the newest copy.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < r_count) && r_valid[r_head + PTR_W'(i)] &&
          (r_tag[r_head + PTR_W'(i)] == w_req_tag)) begin
        w_hit     = 1'b1;
        w_hit_idx = r_head + PTR_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_valid        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
      r_mem_resp     <= 1'b0;
      r_mem_rdata    <= '0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (up.read) begin
            if (w_hit) begin
              r_mem_rdata <= r_data[w_hit_idx];
              r_mem_resp  <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_pmem_read    <= 1'b1;
              r_pmem_address <= {w_req_tag, {OFFSET_W{1'b0}}};
              r_state        <= PMEM_RD;
            end
          end else if (up.write) begin
`ifdef L2_WB_COALESCE_EN
            if (w_hit) begin
              r_data[w_hit_idx] <= up.wdata;
              r_mem_resp        <= 1'b1;
              r_state           <= RESP;
            end else
`endif
            if (!w_full) begin
              r_valid[r_tail] <= 1'b1;
              r_tag[r_tail]   <= w_req_tag;
              r_data[r_tail]  <= up.wdata;
              r_tail          <= r_tail + PTR_W'(1);
              r_count         <= r_count + CNT_W'(1);
              r_mem_resp      <= 1'b1;
              r_state         <= RESP;
            end else begin
              // Full: drain the head first; the write stays pending and is retried from IDLE.
              r_pmem_write   <= 1'b1;
              r_pmem_address <= {r_tag[r_head], {OFFSET_W{1'b0}}};
              r_pmem_wdata   <= r_data[r_head];
              r_state        <= PMEM_WR;
            end
          end else if (r_count != '0) begin
            r_pmem_write   <= 1'b1;
            r_pmem_address <= {r_tag[r_head], {OFFSET_W{1'b0}}};
            r_pmem_wdata   <= r_data[r_head];
            r_state        <= PMEM_WR;
          end
        end
        RESP: begin
          r_mem_resp <= 1'b0;
          r_state    <= IDLE;
        end
        PMEM_RD: begin
          if (pmem.resp) begin
            r_pmem_read <= 1'b0;
            r_mem_rdata <= pmem.rdata;
            r_mem_resp  <= 1'b1;
            r_state     <= RESP;
          end
        end
        PMEM_WR: begin
          if (pmem.resp) begin
            r_pmem_write    <= 1'b0;
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + PTR_W'(1);
            r_count         <= r_count - CNT_W'(1);
            r_state         <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign up.resp      = r_mem_resp;
  assign up.rdata     = r_mem_rdata;
  assign pmem.read    = r_pmem_read;
  assign pmem.write   = r_pmem_write;
  assign pmem.address = r_pmem_address;
  assign pmem.wdata   = r_pmem_wdata;
  assign wb_empty     = (r_count == '0) && !r_pmem_read && !r_pmem_write;
endmodule
